// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response and ALU-side bus of the GF(2^m) ALU sequencer.
//   master : requesters + ALU (drive requests, ALU results, compute_done)
//   slave  : the sequencer (drives req_rdy, responses, busy, ALU operands/pulses)
// Signal names match the original alu_seq port list.
interface alu_seq_if #(
    parameter int unsigned DAT_W = 144
);
    logic [1:0]       req_vld;
    logic [1:0]       req_rdy;
    logic [3:0]       req0_typ;
    logic [3:0]       req1_typ;
    logic [DAT_W:0]   req0_o_dat;
    logic [DAT_W:0]   req1_o_dat;
    logic [DAT_W-1:0] req0_t_dat;
    logic [DAT_W-1:0] req1_t_dat;
    logic [DAT_W:0]   req0_mod_dat;
    logic [DAT_W:0]   req1_mod_dat;

    logic [1:0]       rsp_vld;
    logic             rsp_err;
    logic [DAT_W-1:0] rsp_r_dat1;
    logic [DAT_W-1:0] rsp_r_dat2;
    logic             busy;

    logic [3:0]       alu_typ_sel;
    logic             alu_o_sel;
    logic             alu_t_sel;
    logic             alu_mod_sel;
    logic [DAT_W:0]   alu_o_dat;
    logic [DAT_W-1:0] alu_t_dat;
    logic [DAT_W:0]   alu_mod_dat;
    logic [DAT_W-1:0] alu_r_dat1;
    logic [DAT_W-1:0] alu_r_dat2;
    logic             compute_done;

    modport master (
        output req_vld, req0_typ, req1_typ, req0_o_dat, req1_o_dat,
               req0_t_dat, req1_t_dat, req0_mod_dat, req1_mod_dat,
               alu_r_dat1, alu_r_dat2, compute_done,
        input  req_rdy, rsp_vld, rsp_err, rsp_r_dat1, rsp_r_dat2, busy,
               alu_typ_sel, alu_o_sel, alu_t_sel, alu_mod_sel,
               alu_o_dat, alu_t_dat, alu_mod_dat
    );

    modport slave (
        input  req_vld, req0_typ, req1_typ, req0_o_dat, req1_o_dat,
               req0_t_dat, req1_t_dat, req0_mod_dat, req1_mod_dat,
               alu_r_dat1, alu_r_dat2, compute_done,
        output req_rdy, rsp_vld, rsp_err, rsp_r_dat1, rsp_r_dat2, busy,
               alu_typ_sel, alu_o_sel, alu_t_sel, alu_mod_sel,
               alu_o_dat, alu_t_dat, alu_mod_dat
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: two-port round-robin sequencer in front of the GF(2^m) polynomial ALU.
// Accepts one operation at a time, issues it with a one-cycle select pulse,
// waits for compute_done (bounded by TMO cycles) and returns both result words
// to the originating port. Illegal opcodes are answered with rsp_err at once.
// Ports:
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset
//   bus    : alu_seq_if.slave (requests, responses, busy, ALU operand/result bus)
module alu_seq #(
    parameter int unsigned DAT_W = 144,
    parameter int unsigned TMO   = 1023
) (
    input  logic     clk,
    input  logic     rst_b,
    alu_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             port_q, port_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       typ_q, typ_d;
    logic [DAT_W:0]   o_q, o_d;
    logic [DAT_W-1:0] t_q, t_d;
    logic [DAT_W:0]   mod_q, mod_d;
    logic             sel_q, sel_d;
    logic             mod_sel_q, mod_sel_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic             rsp_err_q, rsp_err_d;
    logic [DAT_W-1:0] r1_q, r1_d;
    logic [DAT_W-1:0] r2_q, r2_d;
    logic             busy_q, busy_d;

    logic [3:0]       in_typ;
    logic [DAT_W:0]   in_o;
    logic [DAT_W-1:0] in_t;
    logic [DAT_W:0]   in_mod;

    function automatic logic op_legal(input logic [3:0] typ);
        return typ inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    endfunction

    function automatic logic op_needs_mod(input logic [3:0] typ);
        return typ inside {4'd3, 4'd8, 4'd9};
    endfunction

    // Only the pointed-to port is ever offered; no path from req_vld.
    assign bus.req_rdy = (state_q == IDLE) ? (ptr_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        port_d    = port_q;
        cnt_d     = cnt_q;
        typ_d     = typ_q;
        o_d       = o_q;
        t_d       = t_q;
        mod_d     = mod_q;
        sel_d     = 1'b0;
        mod_sel_d = 1'b0;
        rsp_vld_d = 2'b00;
        rsp_err_d = rsp_err_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        cnt_inc   = cnt_q + 1'b1;
        in_typ    = ptr_q ? bus.req1_typ     : bus.req0_typ;
        in_o      = ptr_q ? bus.req1_o_dat   : bus.req0_o_dat;
        in_t      = ptr_q ? bus.req1_t_dat   : bus.req0_t_dat;
        in_mod    = ptr_q ? bus.req1_mod_dat : bus.req0_mod_dat;

        unique case (state_q)
            IDLE: begin
                if (bus.req_vld[ptr_q]) begin
                    port_d = ptr_q;
                    ptr_d  = ~ptr_q;
                    if (op_legal(in_typ)) begin
                        state_d   = ISSUE;
                        typ_d     = in_typ;
                        o_d       = in_o;
                        t_d       = in_t;
                        mod_d     = in_mod;
                        sel_d     = 1'b1;
                        mod_sel_d = op_needs_mod(in_typ);
                    end else begin
                        state_d   = RESP;
                        rsp_vld_d = ptr_q ? 2'b10 : 2'b01;
                        rsp_err_d = 1'b1;
                        r1_d      = '0;
                        r2_d      = '0;
                    end
                end else if (bus.req_vld[~ptr_q]) begin
                    // Pointed-to port idle: hand the grant over so the other
                    // port is not starved (req_rdy cannot look at req_vld).
                    ptr_d = ~ptr_q;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.compute_done) begin
                    state_d   = RESP;
                    rsp_vld_d = port_q ? 2'b10 : 2'b01;
                    rsp_err_d = 1'b0;
                    r1_d      = bus.alu_r_dat1;
                    r2_d      = bus.alu_r_dat2;
                end else if (cnt_inc == CNT_W'(TMO)) begin
                    // Count would reach TMO this cycle: WAIT has lasted TMO cycles.
                    state_d   = RESP;
                    rsp_vld_d = port_q ? 2'b10 : 2'b01;
                    rsp_err_d = 1'b1;
                    r1_d      = '0;
                    r2_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            port_q    <= 1'b0;
            cnt_q     <= '0;
            typ_q     <= '0;
            o_q       <= '0;
            t_q       <= '0;
            mod_q     <= '0;
            sel_q     <= 1'b0;
            mod_sel_q <= 1'b0;
            rsp_vld_q <= '0;
            rsp_err_q <= 1'b0;
            r1_q      <= '0;
            r2_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            port_q    <= port_d;
            cnt_q     <= cnt_d;
            typ_q     <= typ_d;
            o_q       <= o_d;
            t_q       <= t_d;
            mod_q     <= mod_d;
            sel_q     <= sel_d;
            mod_sel_q <= mod_sel_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.alu_typ_sel = typ_q;
    assign bus.alu_o_sel   = sel_q;
    assign bus.alu_t_sel   = sel_q;
    assign bus.alu_mod_sel = mod_sel_q;
    assign bus.alu_o_dat   = o_q;
    assign bus.alu_t_dat   = t_q;
    assign bus.alu_mod_dat = mod_q;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_r_dat1  = r1_q;
    assign bus.rsp_r_dat2  = r2_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (DAT_W=16, TMO=15).
// A table of directed vectors, hand sequences for reset/round-robin/stray
// compute_done, and random operations; every operation is predicted by a
// scoreboard (issue cycle, response cycle, port, error, result words).
module tb_alu_seq;
    localparam int DW    = 16;
    localparam int TMO_P = 15;
    localparam int HANG  = 1000;

    typedef logic [DW:0]   ow_t;
    typedef logic [DW-1:0] tw_t;

    typedef struct {
        int         port;
        logic [3:0] typ;
        ow_t        o;
        tw_t        t;
        ow_t        m;
        int         lat;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int   cyc;
        int   port;
        logic err;
        logic chk_dat;
        tw_t  r1;
        tw_t  r2;
    } rsp_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] typ;
        ow_t        o;
        tw_t        t;
        ow_t        m;
    } iss_exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    alu_seq_if #(.DAT_W(DW)) bus ();
    alu_seq #(.DAT_W(DW), .TMO(TMO_P)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    logic [1:0] p_vld = 2'b00;
    logic [3:0] p_typ [2];
    ow_t        p_o   [2];
    tw_t        p_t   [2];
    ow_t        p_m   [2];
    logic       done_drv = 1'b0;
    tw_t        r1_drv = '0;
    tw_t        r2_drv = '0;

    assign bus.req_vld      = p_vld;
    assign bus.req0_typ     = p_typ[0];
    assign bus.req1_typ     = p_typ[1];
    assign bus.req0_o_dat   = p_o[0];
    assign bus.req1_o_dat   = p_o[1];
    assign bus.req0_t_dat   = p_t[0];
    assign bus.req1_t_dat   = p_t[1];
    assign bus.req0_mod_dat = p_m[0];
    assign bus.req1_mod_dat = p_m[1];
    assign bus.compute_done = done_drv;
    assign bus.alu_r_dat1   = r1_drv;
    assign bus.alu_r_dat2   = r2_drv;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_until = -1;
    int last_acc_cyc = 0;
    int last_rsp_cyc = 0;
    logic last_rsp_err = 1'b0;
    int nrsp = 0;
    int rem [2] = '{0, 0};
    int grants [$];
    rsp_exp_t rsp_q [$];
    iss_exp_t iss_q [$];

    int   alu_lat = 0;
    bit   stray_idle = 1'b0;
    bit   stray_issue = 1'b0;
    bit   alu_pend = 1'b0;
    int   alu_cnt = 0;
    tw_t  cap1 = '0;
    tw_t  cap2 = '0;

    vec_t vt [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic is_legal(input logic [3:0] typ);
        return typ inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    endfunction

    function automatic logic uses_mod(input logic [3:0] typ);
        return typ inside {4'd3, 4'd8, 4'd9};
    endfunction

    // Stand-in ALU arithmetic: any fixed function of the operands will do.
    function automatic logic [2*DW-1:0] alu_fn(input logic [3:0] typ, input ow_t o,
                                               input tw_t t, input ow_t m, input logic use_m);
        tw_t r1, r2, tt;
        tt = tw_t'(typ);
        r1 = (o[DW-1:0] + t) ^ tt;
        if (use_m) r2 = (m[DW-1:0] ^ ~t) ^ tw_t'(m[DW]);
        else       r2 = (o[DW-1:0] - t) ^ tw_t'(o[DW]);
        return {r1, r2};
    endfunction

    task automatic load_port(input int p, input logic [3:0] typ);
        p_typ[p] = typ;
        p_o[p]   = ow_t'({$urandom, $urandom});
        p_t[p]   = tw_t'($urandom);
        p_m[p]   = ow_t'({$urandom, $urandom});
    endtask

    // Predict everything about an operation accepted at the end of cycle cyc.
    task automatic accept_port(input int p);
        rsp_exp_t r;
        iss_exp_t s;
        logic [2*DW-1:0] res;
        r.port = p;
        if (is_legal(p_typ[p])) begin
            s.cyc = cyc + 1; s.typ = p_typ[p]; s.o = p_o[p]; s.t = p_t[p]; s.m = p_m[p];
            iss_q.push_back(s);
            if (alu_lat <= TMO_P - 1) begin
                res = alu_fn(p_typ[p], p_o[p], p_t[p], p_m[p], uses_mod(p_typ[p]));
                r.cyc = cyc + 3 + alu_lat; r.err = 1'b0; r.chk_dat = 1'b1;
                r.r1 = res[2*DW-1:DW]; r.r2 = res[DW-1:0];
            end else begin
                r.cyc = cyc + 2 + TMO_P; r.err = 1'b1; r.chk_dat = 1'b1;
                r.r1 = '0; r.r2 = '0;
            end
        end else begin
            r.cyc = cyc + 1; r.err = 1'b1; r.chk_dat = 1'b0; r.r1 = '0; r.r2 = '0;
        end
        rsp_q.push_back(r);
        busy_until = r.cyc;
        grants.push_back(p);
        last_acc_cyc = cyc;
    endtask

    task automatic step();
        logic [1:0] acc;
        rsp_exp_t e;
        iss_exp_t s;
        logic [2*DW-1:0] res;
        acc = p_vld & bus.req_rdy;
        for (int p = 0; p < 2; p++) if (acc[p]) accept_port(p);
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                if (rem[p] > 1) begin
                    rem[p]--;
                    load_port(p, p_typ[p]);
                end else begin
                    rem[p] = 0;
                    p_vld[p] = 1'b0;
                end
            end
        end

        if (rsp_q.size() > 0 && cyc > rsp_q[0].cyc) begin
            fail_now("missing_rsp");
            void'(rsp_q.pop_front());
        end
        if (bus.rsp_vld != 2'b00) begin
            nrsp++;
            last_rsp_cyc = cyc;
            last_rsp_err = bus.rsp_err;
            alu_pend = 1'b0;
            if (rsp_q.size() == 0) begin
                fail_now("spurious_rsp");
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_vld", 64'(bus.rsp_vld), (e.port == 1) ? 64'h2 : 64'h1);
                chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                if (e.chk_dat) begin
                    chk("rsp_r_dat1", 64'(bus.rsp_r_dat1), 64'(e.r1));
                    chk("rsp_r_dat2", 64'(bus.rsp_r_dat2), 64'(e.r2));
                end
            end
        end

        if (iss_q.size() > 0 && cyc > iss_q[0].cyc) begin
            fail_now("missing_issue");
            void'(iss_q.pop_front());
        end
        if (bus.alu_o_sel || bus.alu_t_sel || bus.alu_mod_sel) begin
            if (iss_q.size() == 0) begin
                fail_now("spurious_issue");
            end else begin
                s = iss_q.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(s.cyc));
                chk("alu_ot_sel", {62'b0, bus.alu_o_sel, bus.alu_t_sel}, 64'h3);
                chk("alu_mod_sel", 64'(bus.alu_mod_sel), 64'(uses_mod(s.typ)));
                chk("alu_typ_sel", 64'(bus.alu_typ_sel), 64'(s.typ));
                chk("alu_o_dat", 64'(bus.alu_o_dat), 64'(s.o));
                chk("alu_t_dat", 64'(bus.alu_t_dat), 64'(s.t));
                chk("alu_mod_dat", 64'(bus.alu_mod_dat), 64'(s.m));
            end
        end

        chk("busy", 64'(bus.busy), 64'(cyc <= busy_until));
        chk("req_rdy_idle", 64'(bus.req_rdy == 2'b00), 64'(cyc <= busy_until));

        // ALU responder: done after alu_lat WAIT cycles; results valid only with done.
        if (bus.alu_o_sel) begin
            res = alu_fn(bus.alu_typ_sel, bus.alu_o_dat, bus.alu_t_dat, bus.alu_mod_dat,
                         bus.alu_mod_sel);
            cap1 = res[2*DW-1:DW];
            cap2 = res[DW-1:0];
            alu_pend = 1'b1;
            alu_cnt = alu_lat;
            done_drv = stray_issue;
        end else if (alu_pend) begin
            if (alu_cnt == 0) begin
                done_drv = 1'b1;
                alu_pend = 1'b0;
            end else begin
                alu_cnt--;
                done_drv = 1'b0;
            end
        end else begin
            done_drv = stray_idle;
        end
        r1_drv = done_drv ? cap1 : ~cap1;
        r2_drv = done_drv ? cap2 : ~cap2;
    endtask

    task automatic check_reset_vals();
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'h1);
        chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'h0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("rst_rsp_r_dat", {bus.rsp_r_dat1, bus.rsp_r_dat2}, 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_sel", {61'b0, bus.alu_o_sel, bus.alu_t_sel, bus.alu_mod_sel}, 64'h0);
        chk("rst_typ_sel", 64'(bus.alu_typ_sel), 64'h0);
        chk("rst_alu_dat", 64'(bus.alu_o_dat) | 64'(bus.alu_t_dat) | 64'(bus.alu_mod_dat), 64'h0);
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int n;
        int g0;
        int r0;
        p_typ[v.port] = v.typ;
        p_o[v.port]   = v.o;
        p_t[v.port]   = v.t;
        p_m[v.port]   = v.m;
        alu_lat = v.lat;
        rem[v.port] = 1;
        p_vld[v.port] = 1'b1;
        g0 = grants.size();
        r0 = nrsp;
        n = 0;
        while (grants.size() == g0 && n < 40) begin step(); n++; end
        if (grants.size() == g0) begin
            fail_now({tag, "_accept_timeout"});
            p_vld[v.port] = 1'b0;
            return;
        end
        n = 0;
        while (nrsp == r0 && n < 40) begin step(); n++; end
        if (nrsp == r0) begin
            fail_now({tag, "_rsp_timeout"});
            return;
        end
        chk({tag, "_latency"}, 64'(last_rsp_cyc - last_acc_cyc), 64'(v.exp_lat));
        chk({tag, "_err"}, 64'(last_rsp_err), 64'(v.exp_err));
        chk({tag, "_grant_port"}, 64'(grants[grants.size() - 1]), 64'(v.port));
    endtask

    initial begin
        vec_t rv;
        int n;
        int g0;
        int sel;

        vt[0]  = '{0, 4'h1, 17'h0fff1, 16'h0f0f, 17'h1002b, 3,    6,  1'b0};
        vt[1]  = '{1, 4'h3, 17'h1a5a5, 16'h1234, 17'h1100b, 0,    3,  1'b0};
        vt[2]  = '{1, 4'h4, 17'h00001, 16'h0002, 17'h00003, 0,    1,  1'b1};
        vt[3]  = '{0, 4'h0, 17'h0beef, 16'hcafe, 17'h10001, 0,    1,  1'b1};
        vt[4]  = '{0, 4'hf, 17'h12345, 16'h6789, 17'h1abcd, 0,    1,  1'b1};
        vt[5]  = '{1, 4'h5, 17'h0f00f, 16'h00ff, 17'h10003, 2,    5,  1'b0};
        vt[6]  = '{0, 4'h8, 17'h1ffff, 16'hffff, 17'h1001b, 1,    4,  1'b0};
        vt[7]  = '{1, 4'h9, 17'h00000, 16'h8001, 17'h18005, 5,    8,  1'b0};
        vt[8]  = '{0, 4'h7, 17'h0aaaa, 16'h5555, 17'h00000, HANG, 17, 1'b1};
        vt[9]  = '{0, 4'h2, 17'h13579, 16'h2468, 17'h00000, 0,    3,  1'b0};
        vt[10] = '{1, 4'h1, 17'h00f0f, 16'hf0f0, 17'h00000, 14,   17, 1'b0};
        vt[11] = '{0, 4'h6, 17'h07777, 16'h1111, 17'h1ffff, 4,    7,  1'b0};
        vt[12] = '{1, 4'ha, 17'h00042, 16'h0042, 17'h00042, 0,    1,  1'b1};

        for (int p = 0; p < 2; p++) load_port(p, 4'h0);
        rst_b = 1'b0;
        #1;
        check_reset_vals();
        step();
        step();
        rst_b = 1'b1;

        for (int i = 0; i < 13; i++) run_one(vt[i], $sformatf("vec%0d", i));

        // Stray compute_done in IDLE/RESP and in the ISSUE cycle must be ignored.
        stray_idle = 1'b1;
        stray_issue = 1'b1;
        for (int i = 0; i < 4; i++) step();
        run_one('{0, 4'h1, 17'h01234, 16'h4321, 17'h0, 2, 5, 1'b0}, "stray_add");
        run_one('{1, 4'hc, 17'h0, 16'h0, 17'h0, 0, 1, 1'b1}, "stray_illegal");
        run_one('{1, 4'h3, 17'h1beef, 16'h0bad, 17'h1c001, TMO_P - 1, 17, 1'b0}, "stray_tmo_tie");
        stray_idle = 1'b0;
        stray_issue = 1'b0;

        for (int i = 0; i < 30; i++) begin
            rv.port = int'($urandom_range(1, 0));
            rv.typ  = 4'($urandom_range(15, 0));
            rv.o    = ow_t'({$urandom, $urandom});
            rv.t    = tw_t'($urandom);
            rv.m    = ow_t'({$urandom, $urandom});
            sel     = int'($urandom_range(9, 0));
            rv.lat  = (sel < 7) ? int'($urandom_range(4, 0)) : ((sel == 7) ? TMO_P - 1 : HANG);
            rv.exp_err = !is_legal(rv.typ) || (rv.lat > TMO_P - 1);
            rv.exp_lat = !is_legal(rv.typ) ? 1 : ((rv.lat <= TMO_P - 1) ? 3 + rv.lat : 2 + TMO_P);
            run_one(rv, $sformatf("rnd%0d", i));
        end

        // Reset during WAIT of a div: no response may ever appear for it.
        p_typ[1] = 4'h5;
        load_port(1, 4'h5);
        alu_lat = HANG;
        rem[1] = 1;
        p_vld[1] = 1'b1;
        g0 = grants.size();
        n = 0;
        while (grants.size() == g0 && n < 40) begin step(); n++; end
        if (grants.size() == g0) fail_now("rst_div_accept_timeout");
        step();
        step();
        #1 rst_b = 1'b0;
        #1;
        check_reset_vals();
        rsp_q.delete();
        iss_q.delete();
        busy_until = -1;
        alu_pend = 1'b0;
        done_drv = 1'b0;
        p_vld = 2'b00;
        step();
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Both ports continuously valid with mul: grants 0,1,0,1 starting at port 0.
        load_port(0, 4'h3);
        load_port(1, 4'h3);
        alu_lat = 1;
        rem[0] = 2;
        rem[1] = 2;
        g0 = grants.size();
        p_vld = 2'b11;
        n = 0;
        while ((grants.size() - g0 < 4 || rsp_q.size() > 0) && n < 60) begin step(); n++; end
        if (grants.size() - g0 < 4) begin
            fail_now("rr_grant_timeout");
        end else begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("rr_grant%0d", k), 64'(grants[g0 + k]), 64'(k % 2));
        end
        p_vld = 2'b00;
        for (int i = 0; i < 3; i++) step();

        chk("scoreboard_rsp_drained", 64'(rsp_q.size()), 64'h0);
        chk("scoreboard_issue_drained", 64'(iss_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer and two-port arbiter in front of the GF(2^m) polynomial ALU. Accepts complete ALU operations (opcode plus operands) from two requesters, typically the instruction decoder (port 0) and the key/syndrome loader (port 1). Issues one operation at a time using the ALU's single-cycle select-pulse protocol, waits for `compute_done`, then returns both result words to the originating requester. Also handles illegal opcodes and a hung ALU.

## Interface
Parameters:
- `DAT_W`, 144: ALU data width; operand `o` and modulus are `DAT_W+1` bits.
- `TMO`, 1023: maximum cycles spent in WAIT before the operation is aborted.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `req_vld` in 2: per-port request valid, bit i = port i.
- `req_rdy` out 2: per-port accept; an operation transfers when `req_vld[i] & req_rdy[i]`.
- `req0_typ`, `req1_typ` in 4: opcode for each port.
- `req0_o_dat`, `req1_o_dat` in `DAT_W+1`: operand o for each port.
- `req0_t_dat`, `req1_t_dat` in `DAT_W`: operand t for each port.
- `req0_mod_dat`, `req1_mod_dat` in `DAT_W+1`: modulus polynomial for each port.
- `rsp_vld` out 2: one-hot, one-cycle response strobe to the originating port.
- `rsp_err` out 1: qualifies `rsp_vld`; set on illegal opcode or timeout.
- `rsp_r_dat1`, `rsp_r_dat2` out `DAT_W`: result words, held until the next response.
- `busy` out 1: high in every state except IDLE.
- `alu_typ_sel` out 4: ALU opcode.
- `alu_o_sel`, `alu_t_sel`, `alu_mod_sel` out 1: ALU load pulses.
- `alu_o_dat` out `DAT_W+1`, `alu_t_dat` out `DAT_W`, `alu_mod_dat` out `DAT_W+1`: ALU operands.
- `alu_r_dat1`, `alu_r_dat2` in `DAT_W`: ALU results.
- `compute_done` in 1: ALU completion.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_rdy[g]=1` only for the granted port g; the other bit is 0.
  - Round-robin: if both ports are valid, grant the port not served last. After reset, port 0 has priority.
  - On accept, latch port, opcode and operands.
  - Legal opcode goes to ISSUE; illegal opcode goes to RESP with error.
- Legal opcodes:
  - 0001 add, 0010 split, 0011 mul, 0101 div, 0110 inv, 0111 deg, 1000 shift, 1001 eval.
  - Opcodes 0011, 1000 and 1001 need the modulus.
  - Illegal: 0000, 0100, 1010–1111.
- ISSUE (exactly 1 cycle):
  - `alu_o_sel=alu_t_sel=1`.
  - `alu_mod_sel=1` only for the modulus opcodes.
  - `alu_typ_sel`, `alu_*_dat` driven from the latched values.
  - Next state: WAIT, with the timeout counter cleared.
- WAIT:
  - All select pulses are 0; opcode and operands stay stable.
  - The counter increments each cycle.
  - `compute_done=1`: capture `alu_r_dat1/2` into `rsp_r_dat1/2`, clear error, go to RESP.
  - Counter reaches `TMO` without `compute_done`: results forced to 0, error set, go to RESP.
- RESP (1 cycle): `rsp_vld[port]=1` and `rsp_err` valid; next state IDLE. Responses have no backpressure.
- `compute_done` is ignored in every state except WAIT, including the ISSUE cycle.
- If `compute_done` and the timeout occur in the same cycle, `compute_done` wins: normal response, `rsp_err=0`.
- Requests arriving while busy are held off by `req_rdy=0`. Requesters keep their operands stable until accepted.
- The round-robin pointer updates on accept, including accepts of illegal opcodes.

## Timing
- Reset values:
  - State IDLE, round-robin pointer at port 0.
  - `req_rdy` = 2'b01 (port 0 granted first).
  - All `rsp_*`, `busy`, `alu_*_sel`, `alu_typ_sel` and `alu_*_dat` = 0.
- Outputs are registered, except `req_rdy`, which decodes from state and pointer only (no combinational path from `req_vld`).
- Cycle timing for an accept at cycle A:
  - Cycle A+1: ISSUE pulse.
  - First `compute_done` sampled at A+2 at the earliest.
  - `rsp_vld` appears the cycle after `compute_done`.
  - The next accept is possible the cycle after RESP.
- Minimum turnaround is 4 cycles per operation. An illegal opcode gives `rsp_vld` at A+1.
- Timeout: `rsp_vld` at A+2+`TMO`.
- Reset asserted mid-operation: immediate return to reset values. No response is ever issued for the aborted operation.

## Test plan
- Port 0 add, 0001, o=16'hfff1, t=16'h0f0f:
  - One-cycle `alu_o_sel`/`alu_t_sel` pulse with `alu_mod_sel=0`.
  - ALU model asserts done 3 cycles later.
  - Expect `rsp_vld`=2'b01, `rsp_err`=0, `rsp_r_dat1` equal to the model result, and 6 cycles from accept to response.
- Both ports valid continuously with mul (0011) on both:
  - Grants alternate 0,1,0,1.
  - `alu_mod_sel`=1 on every issue.
  - Each response goes to the matching port.
- Port 1 opcode 0100: no ALU select pulses; `rsp_vld`=2'b10 with `rsp_err`=1 one cycle after accept.
- ALU model never asserts done, `TMO`=15:
  - `rsp_err`=1 with both result words 0, exactly 17 cycles after accept.
  - The next request is then accepted normally.
- Stray `compute_done` in IDLE and in the ISSUE cycle:
  - Ignored, no response.
  - `compute_done` together with the timeout at count `TMO` gives `rsp_err`=0.
- `rst_b` pulsed low during WAIT of a div (0101):
  - Outputs are at reset values immediately and no `rsp_vld` is produced.
  - After release, port 0 gets priority.
